// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage.
//   - Opcode encodings and instruction field positions used by every stage.
//   - Fetch FSM state encoding.
//   - is_jmp(): recognises the unconditional jump that fetch resolves locally.
package instruction_fetch_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_JMP = 4'h1,
        OP_BLE = 4'h2,
        OP_ADD = 4'h3,
        OP_STO = 4'h4,
        OP_VGA = 4'h5,
        OP_LED = 4'h6
    } opcode_t;

    // Instruction field positions: op [27:24], dst [23:16], src1 [15:8], src0 [7:0]
    localparam int unsigned OP_HI   = 27;
    localparam int unsigned OP_LO   = 24;
    localparam int unsigned DST_HI  = 23;
    localparam int unsigned DST_LO  = 16;
    localparam int unsigned SRC1_HI = 15;
    localparam int unsigned SRC1_LO = 8;
    localparam int unsigned SRC0_HI = 7;
    localparam int unsigned SRC0_LO = 0;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_jmp(input logic [3:0] op);
        return op == OP_JMP;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, the decode handshake slot and the
// execute redirect port.
//   master (fetch):  drives oAddress, oInstruction, oPC, oInstrValid
//                    receives iInstruction, iDecodeReady, iBranchTaken, iBranchTarget
//   slave  (ROM/decode/execute side): the mirror image
interface instruction_fetch_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 28
);
    logic [ADDR_W-1:0]  oAddress;
    logic [INSTR_W-1:0] iInstruction;
    logic [INSTR_W-1:0] oInstruction;
    logic [ADDR_W-1:0]  oPC;
    logic               oInstrValid;
    logic               iDecodeReady;
    logic               iBranchTaken;
    logic [ADDR_W-1:0]  iBranchTarget;

    modport master (
        output oAddress,
        input  iInstruction,
        output oInstruction,
        output oPC,
        output oInstrValid,
        input  iDecodeReady,
        input  iBranchTaken,
        input  iBranchTarget
    );

    modport slave (
        input  oAddress,
        output iInstruction,
        input  oInstruction,
        input  oPC,
        input  oInstrValid,
        output iDecodeReady,
        output iBranchTaken,
        output iBranchTarget
    );
endinterface

// File: rtl/instruction_fetch_pc_next.sv
// Combinational next-PC selection.
//   pc            in  : current program counter
//   opcode        in  : op field of the ROM word at pc
//   jmp_dst       in  : dst field of the ROM word (JMP target)
//   branch_taken  in  : execute redirect
//   branch_target in  : redirect address
//   next_pc       out : redirect target > folded JMP target > pc+1 (wrapping)
module instruction_fetch_pc_next
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [3:0]        opcode,
    input  logic [7:0]        jmp_dst,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] next_pc
);
    always_comb begin
        next_pc = pc + ADDR_W'(1);
        if (branch_taken) begin
            next_pc = branch_target;
        end else if (is_jmp(opcode)) begin
            next_pc = ADDR_W'(jmp_dst);
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational ROM and registers the
// returned word into a single valid/ready slot for decode. JMP is folded here
// (no bubble); execute redirects through iBranchTaken/iBranchTarget.
//   Clock    in  : rising-edge clock
//   Reset    in  : asynchronous active-low reset
//   iStart   in  : IDLE/HALT -> RUN
//   iHalt    in  : RUN -> HALT (wins over iStart)
//   oRunning out : registered, high while in RUN
//   bus          : ROM port, decode slot and redirect port (master side)
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 28,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iStart,
    input  logic                iHalt,
    output logic                oRunning,
    instruction_fetch_if.master bus
);
    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  next_pc;
    logic [INSTR_W-1:0] slot;
    logic [ADDR_W-1:0]  slot_pc;
    logic               slot_valid;
    logic               running;
    logic               advance;

    instruction_fetch_pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc            (pc),
        .opcode        (bus.iInstruction[OP_HI:OP_LO]),
        .jmp_dst       (bus.iInstruction[DST_HI:DST_LO]),
        .branch_taken  (bus.iBranchTaken),
        .branch_target (bus.iBranchTarget),
        .next_pc       (next_pc)
    );

    assign advance = (state == FETCH_RUN) && !bus.iBranchTaken &&
                     (!slot_valid || bus.iDecodeReady);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= FETCH_IDLE;
            running    <= 1'b0;
            pc         <= RESET_PC;
            slot       <= '0;
            slot_pc    <= '0;
            slot_valid <= 1'b0;
        end else begin
            // running is assigned alongside state so it never lags it
            case (state)
                FETCH_IDLE: if (iStart) begin
                    state   <= FETCH_RUN;
                    running <= 1'b1;
                end
                FETCH_RUN: if (iHalt) begin
                    state   <= FETCH_HALT;
                    running <= 1'b0;
                end
                FETCH_HALT: if (iStart) begin
                    state   <= FETCH_RUN;
                    running <= 1'b1;
                end
                default: begin
                    state   <= FETCH_IDLE;
                    running <= 1'b0;
                end
            endcase

            if (bus.iBranchTaken) begin
                // squash the slot even if decode is ready; ROM word discarded
                pc         <= next_pc;
                slot_valid <= 1'b0;
            end else if (advance) begin
                slot       <= bus.iInstruction;
                slot_pc    <= pc;
                slot_valid <= 1'b1;
                pc         <= next_pc;
            end else if (bus.iDecodeReady && slot_valid) begin
                slot_valid <= 1'b0;
            end
        end
    end

    assign bus.oAddress     = pc;
    assign bus.oInstruction = slot;
    assign bus.oPC          = slot_pc;
    assign bus.oInstrValid  = slot_valid;
    assign oRunning         = running;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: one DUT with the default reset PC and
// a small program (word k at address k, JMP 13 at address 14), and a second
// DUT starting at 16'hFFFE over an all-NOP ROM.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clk;
    logic rst_n;
    logic start_a, halt_a, running_a;
    logic start_b, halt_b, running_b;
    int   checks;
    int   errors;

    instruction_fetch_if #(.ADDR_W(16), .INSTR_W(28)) bus_a ();
    instruction_fetch_if #(.ADDR_W(16), .INSTR_W(28)) bus_b ();

    instruction_fetch #(
        .ADDR_W   (16),
        .INSTR_W  (28),
        .RESET_PC (16'h0000)
    ) dut_a (
        .Clock    (clk),
        .Reset    (rst_n),
        .iStart   (start_a),
        .iHalt    (halt_a),
        .oRunning (running_a),
        .bus      (bus_a)
    );

    instruction_fetch #(
        .ADDR_W   (16),
        .INSTR_W  (28),
        .RESET_PC (16'hFFFE)
    ) dut_b (
        .Clock    (clk),
        .Reset    (rst_n),
        .iStart   (start_b),
        .iHalt    (halt_b),
        .oRunning (running_b),
        .bus      (bus_b)
    );

    function automatic logic [27:0] rom_a(input logic [15:0] a);
        if (a == 16'd14) return {OP_JMP, 8'd13, 16'h0000};
        return {12'h000, a};
    endfunction

    assign bus_a.iInstruction = rom_a(bus_a.oAddress);
    assign bus_b.iInstruction = {OP_NOP, 24'h000000};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++; if (bus_a.oAddress !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected %h", bus_a.oAddress, 16'h0000); end
        checks++; if (bus_a.oInstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus_a.oInstrValid); end
        checks++; if (running_a !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running_a); end
        checks++; if (bus_a.oPC !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus_a.oPC, 16'h0000); end
        checks++; if (bus_a.oInstruction !== 28'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus_a.oInstruction); end
        checks++; if (bus_b.oAddress !== 16'hFFFE) begin errors++; $display("FAIL reset_addr_b: got %h expected %h", bus_b.oAddress, 16'hFFFE); end
        rst_n = 1'b1;
    endtask

    task automatic test_start;
        logic [15:0] k16;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        checks++; if (running_a !== 1'b1) begin errors++; $display("FAIL start_running: got %b expected 1", running_a); end
        checks++; if (bus_a.oInstrValid !== 1'b0) begin errors++; $display("FAIL start_valid0: got %b expected 0", bus_a.oInstrValid); end
        for (int k = 0; k < 4; k++) begin
            tick;
            k16 = 16'(k);
            checks++; if (bus_a.oPC !== k16) begin errors++; $display("FAIL start_pc[%0d]: got %h expected %h", k, bus_a.oPC, k16); end
            checks++; if (bus_a.oInstrValid !== 1'b1) begin errors++; $display("FAIL start_valid[%0d]: got %b expected 1", k, bus_a.oInstrValid); end
            checks++; if (bus_a.oInstruction !== {12'h000, k16}) begin errors++; $display("FAIL start_instr[%0d]: got %h expected %h", k, bus_a.oInstruction, {12'h000, k16}); end
        end
    endtask

    task automatic test_backpressure;
        tick;
        tick;
        checks++; if (bus_a.oPC !== 16'd5) begin errors++; $display("FAIL bp_pc_pre: got %h expected %h", bus_a.oPC, 16'd5); end
        bus_a.iDecodeReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (bus_a.oPC !== 16'd5) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected %h", i, bus_a.oPC, 16'd5); end
            checks++; if (bus_a.oInstruction !== 28'd5) begin errors++; $display("FAIL bp_instr[%0d]: got %h expected %h", i, bus_a.oInstruction, 28'd5); end
            checks++; if (bus_a.oInstrValid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus_a.oInstrValid); end
            checks++; if (bus_a.oAddress !== 16'd6) begin errors++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, bus_a.oAddress, 16'd6); end
        end
        bus_a.iDecodeReady = 1'b1;
        tick;
        checks++; if (bus_a.oPC !== 16'd6) begin errors++; $display("FAIL bp_release_pc: got %h expected %h", bus_a.oPC, 16'd6); end
    endtask

    task automatic test_branch;
        for (int i = 0; i < 6; i++) tick;
        checks++; if (bus_a.oPC !== 16'd12) begin errors++; $display("FAIL br_pc_pre: got %h expected %h", bus_a.oPC, 16'd12); end
        bus_a.iDecodeReady  = 1'b0;
        bus_a.iBranchTaken  = 1'b1;
        bus_a.iBranchTarget = 16'd6;
        tick;
        bus_a.iBranchTaken  = 1'b0;
        bus_a.iBranchTarget = 16'd0;
        checks++; if (bus_a.oInstrValid !== 1'b0) begin errors++; $display("FAIL br_squash: got %b expected 0", bus_a.oInstrValid); end
        checks++; if (bus_a.oAddress !== 16'd6) begin errors++; $display("FAIL br_addr: got %h expected %h", bus_a.oAddress, 16'd6); end
        bus_a.iDecodeReady = 1'b1;
        tick;
        checks++; if (bus_a.oPC !== 16'd6) begin errors++; $display("FAIL br_target_pc: got %h expected %h", bus_a.oPC, 16'd6); end
        checks++; if (bus_a.oInstrValid !== 1'b1) begin errors++; $display("FAIL br_target_valid: got %b expected 1", bus_a.oInstrValid); end
    endtask

    task automatic test_jmp_fold;
        logic [15:0] exp_seq [3];
        exp_seq[0] = 16'd13;
        exp_seq[1] = 16'd14;
        exp_seq[2] = 16'd13;
        for (int i = 0; i < 8; i++) tick;
        checks++; if (bus_a.oPC !== 16'd14) begin errors++; $display("FAIL jmp_pc: got %h expected %h", bus_a.oPC, 16'd14); end
        checks++; if (bus_a.oInstruction !== {OP_JMP, 8'd13, 16'h0000}) begin errors++; $display("FAIL jmp_instr: got %h expected %h", bus_a.oInstruction, {OP_JMP, 8'd13, 16'h0000}); end
        checks++; if (bus_a.oAddress !== 16'd13) begin errors++; $display("FAIL jmp_addr: got %h expected %h", bus_a.oAddress, 16'd13); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (bus_a.oPC !== exp_seq[i]) begin errors++; $display("FAIL jmp_loop_pc[%0d]: got %h expected %h", i, bus_a.oPC, exp_seq[i]); end
            checks++; if (bus_a.oInstrValid !== 1'b1) begin errors++; $display("FAIL jmp_loop_valid[%0d]: got %b expected 1", i, bus_a.oInstrValid); end
        end
    endtask

    task automatic test_halt_branch;
        halt_a              = 1'b1;
        bus_a.iBranchTaken  = 1'b1;
        bus_a.iBranchTarget = 16'd3;
        tick;
        halt_a              = 1'b0;
        bus_a.iBranchTaken  = 1'b0;
        bus_a.iBranchTarget = 16'd0;
        checks++; if (running_a !== 1'b0) begin errors++; $display("FAIL hb_running: got %b expected 0", running_a); end
        checks++; if (bus_a.oInstrValid !== 1'b0) begin errors++; $display("FAIL hb_valid: got %b expected 0", bus_a.oInstrValid); end
        checks++; if (bus_a.oAddress !== 16'd3) begin errors++; $display("FAIL hb_addr: got %h expected %h", bus_a.oAddress, 16'd3); end
        tick;
        checks++; if (bus_a.oAddress !== 16'd3) begin errors++; $display("FAIL hb_addr_hold: got %h expected %h", bus_a.oAddress, 16'd3); end
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        checks++; if (running_a !== 1'b1) begin errors++; $display("FAIL hb_restart: got %b expected 1", running_a); end
        tick;
        checks++; if (bus_a.oPC !== 16'd3) begin errors++; $display("FAIL hb_resume_pc: got %h expected %h", bus_a.oPC, 16'd3); end
        checks++; if (bus_a.oInstrValid !== 1'b1) begin errors++; $display("FAIL hb_resume_valid: got %b expected 1", bus_a.oInstrValid); end
    endtask

    task automatic test_async_reset;
        tick;
        checks++; if (bus_a.oInstrValid !== 1'b1) begin errors++; $display("FAIL ar_valid_pre: got %b expected 1", bus_a.oInstrValid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.oInstrValid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", bus_a.oInstrValid); end
        checks++; if (running_a !== 1'b0) begin errors++; $display("FAIL ar_running: got %b expected 0", running_a); end
        checks++; if (bus_a.oPC !== 16'h0000) begin errors++; $display("FAIL ar_pc: got %h expected %h", bus_a.oPC, 16'h0000); end
        checks++; if (bus_a.oAddress !== 16'h0000) begin errors++; $display("FAIL ar_addr: got %h expected %h", bus_a.oAddress, 16'h0000); end
        #2;
        rst_n = 1'b1;
        tick;
        tick;
        checks++; if (running_a !== 1'b0) begin errors++; $display("FAIL ar_idle: got %b expected 0", running_a); end
        checks++; if (bus_a.oInstrValid !== 1'b0) begin errors++; $display("FAIL ar_idle_valid: got %b expected 0", bus_a.oInstrValid); end
    endtask

    task automatic test_wrap_halt;
        bus_b.iDecodeReady = 1'b1;
        checks++; if (bus_b.oAddress !== 16'hFFFE) begin errors++; $display("FAIL wrap_reset_addr: got %h expected %h", bus_b.oAddress, 16'hFFFE); end
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        tick;
        checks++; if (bus_b.oPC !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc0: got %h expected %h", bus_b.oPC, 16'hFFFE); end
        tick;
        checks++; if (bus_b.oPC !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc1: got %h expected %h", bus_b.oPC, 16'hFFFF); end
        halt_b = 1'b1;
        tick;
        halt_b = 1'b0;
        checks++; if (bus_b.oPC !== 16'h0000) begin errors++; $display("FAIL wrap_pc2: got %h expected %h", bus_b.oPC, 16'h0000); end
        checks++; if (running_b !== 1'b0) begin errors++; $display("FAIL wrap_halt_running: got %b expected 0", running_b); end
        checks++; if (bus_b.oAddress !== 16'h0001) begin errors++; $display("FAIL wrap_halt_addr: got %h expected %h", bus_b.oAddress, 16'h0001); end
        tick;
        checks++; if (bus_b.oAddress !== 16'h0001) begin errors++; $display("FAIL wrap_frozen_addr: got %h expected %h", bus_b.oAddress, 16'h0001); end
        checks++; if (bus_b.oInstrValid !== 1'b0) begin errors++; $display("FAIL wrap_drained: got %b expected 0", bus_b.oInstrValid); end
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        checks++; if (running_b !== 1'b1) begin errors++; $display("FAIL wrap_restart: got %b expected 1", running_b); end
        tick;
        checks++; if (bus_b.oPC !== 16'h0001) begin errors++; $display("FAIL wrap_resume_pc: got %h expected %h", bus_b.oPC, 16'h0001); end
        checks++; if (bus_b.oInstrValid !== 1'b1) begin errors++; $display("FAIL wrap_resume_valid: got %b expected 1", bus_b.oInstrValid); end
    endtask

    initial begin
        checks              = 0;
        errors              = 0;
        rst_n               = 1'b0;
        start_a             = 1'b0;
        halt_a              = 1'b0;
        start_b             = 1'b0;
        halt_b              = 1'b0;
        bus_a.iDecodeReady  = 1'b1;
        bus_a.iBranchTaken  = 1'b0;
        bus_a.iBranchTarget = 16'h0000;
        bus_b.iDecodeReady  = 1'b1;
        bus_b.iBranchTaken  = 1'b0;
        bus_b.iBranchTarget = 16'h0000;

        test_reset;
        test_start;
        test_backpressure;
        test_branch;
        test_jmp_fold;
        test_halt_branch;
        test_async_reset;
        test_wrap_halt;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
